// File: rtl/vdp_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vdp_vram_arbiter
// Purpose  : Shares the single-port VRAM between the background fetcher,
//            the sprite fetcher and the CPU data port. One access per cycle,
//            read data returned with a per-requester valid/ack.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_vram_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic              sp_req,
  input  logic [ADDR_W-1:0] sp_addr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [ADDR_W-1:0] vram_a,
  output logic              vram_we,
  output logic [7:0]        vram_dout,
  input  logic [7:0]        vram_din,
  output logic [7:0]        rdata,
  output logic              bg_valid,
  output logic              sp_valid,
  output logic              cpu_ack
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  // Tags travelling alongside each issued access
  localparam logic [2:0] TAG_IDLE   = 3'd0;
  localparam logic [2:0] TAG_BG     = 3'd1;
  localparam logic [2:0] TAG_SP     = 3'd2;
  localparam logic [2:0] TAG_CPU_RD = 3'd3;
  localparam logic [2:0] TAG_CPU_WR = 3'd4;

  logic             cpu_busy;
  logic [CNT_W-1:0] starve_cnt;
  logic [2:0]       tag_s1;
  logic [2:0]       tag_s2;

  logic              cpu_elig;
  logic              starved;
  logic              grant_any;
  logic              grant_cpu;
  logic [2:0]        grant_tag;
  logic [ADDR_W-1:0] grant_addr;

  // A held CPU request may only be granted once; busy covers grant..ack
  assign cpu_elig = cpu_req & ~cpu_busy;
  assign starved  = (starve_cnt == STARVE_MAX);

  // Grant selection: bg first; a starved CPU jumps ahead of sprite
  always_comb begin
    grant_tag  = TAG_IDLE;
    grant_addr = bg_addr;
    if (bg_req) begin
      grant_tag  = TAG_BG;
      grant_addr = bg_addr;
    end else if (cpu_elig && starved) begin
      grant_tag  = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      grant_addr = cpu_addr;
    end else if (sp_req) begin
      grant_tag  = TAG_SP;
      grant_addr = sp_addr;
    end else if (cpu_elig) begin
      grant_tag  = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      grant_addr = cpu_addr;
    end
  end

  assign grant_any = (grant_tag != TAG_IDLE);
  assign grant_cpu = (grant_tag == TAG_CPU_RD) || (grant_tag == TAG_CPU_WR);

  // Register the winning access so it is presented to VRAM next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vram_a    <= '0;
      vram_we   <= 1'b0;
      vram_dout <= 8'h00;
    end else begin
      vram_we <= (grant_tag == TAG_CPU_WR);
      if (grant_any) begin
        vram_a <= grant_addr;
      end
      if (grant_tag == TAG_CPU_WR) begin
        vram_dout <= cpu_wdata;
      end
    end
  end

  // Two-stage tag pipeline matching the synchronous RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_s1 <= TAG_IDLE;
      tag_s2 <= TAG_IDLE;
    end else begin
      tag_s1 <= grant_tag;
      tag_s2 <= tag_s1;
    end
  end

  // CPU handshake tracking and starvation counting
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_busy   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (grant_cpu) begin
        cpu_busy <= 1'b1;
      end else if (cpu_ack) begin
        cpu_busy <= 1'b0;
      end

      if (!cpu_req || grant_cpu) begin
        starve_cnt <= '0;
      end else if (cpu_elig && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // Writes complete when presented; reads when the RAM data returns
  assign rdata    = vram_din;
  assign bg_valid = (tag_s2 == TAG_BG);
  assign sp_valid = (tag_s2 == TAG_SP);
  assign cpu_ack  = (tag_s1 == TAG_CPU_WR) || (tag_s2 == TAG_CPU_RD);

endmodule
`default_nettype wire
